exe_stage: RTL and testbench

- Pipeline stage 4: executes the instruction latched from ID and feeds the MEM stage through EXE_to_MEM_bus.
- Contains the ALU, a single-cycle 32x32 low multiplier and an iterative radix-2 divider FSM.
- Issues the synchronous data RAM request, so load data returns while the instruction is in MEM.
- Drives the EXE-stage bypass bus.

---
 rtl/exe_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_exe_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage : pipeline execute stage.
//   Takes the instruction latched from ID and runs the ALU, the single-cycle
//   32x32 low multiplier, or an iterative restoring radix-2 divider on it.
//   It issues the synchronous data RAM request on the cycle the instruction
//   moves to MEM, so load data comes back while the instruction is in MEM.
//   It also drives the EXE-stage bypass bus.
//
// Ports
//   clk, reset         clock; asynchronous active-low reset
//   ID_to_EXE_bus/valid  instruction from ID (148 bits) and its valid
//   EXE_allow_in       EXE can accept a new instruction this cycle
//   MEM_allow_in       MEM can accept an instruction this cycle
//   EXE_to_MEM_valid/bus  instruction to MEM (79 bits) and its valid
//   EXE_to_BY_bus      bypass: {waddr, exe_result, data_valid, rf_w_en}
//   data_ram_*         data RAM request: enable, byte WE, address, data
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no divide in progress; operands latched when a divide op is in EXE
// BUSY  | one restoring quotient step per cycle
// DONE  | quotient/remainder valid and held until MEM accepts the instruction
// ---------------------------------------------------------------------------
module exe_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [147:0] ID_to_EXE_bus,
    input  logic         ID_to_EXE_valid,
    output logic         EXE_allow_in,
    input  logic         MEM_allow_in,
    output logic         EXE_to_MEM_valid,
    output logic [78:0]  EXE_to_MEM_bus,
    output logic [38:0]  EXE_to_BY_bus,
    output logic         data_ram_en,
    output logic [3:0]   data_ram_we,
    output logic [31:0]  data_ram_addr,
    output logic [31:0]  data_ram_w_data
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

    logic [147:0] id_to_exe_q;
    logic         exe_valid_q;
    div_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]  quo_q, quo_d;
    logic [31:0]  rem_q, rem_d;
    logic [31:0]  dvs_q, dvs_d;
    logic         q_neg_q, q_neg_d;
    logic         r_neg_q, r_neg_d;
    logic         dz_q, dz_d;

    logic         exe_ready_go;

    // instruction fields
    logic [31:0] store_data, src1, src2, inst_pc;
    logic [3:0]  exe_op, b_en;
    logic [2:0]  sel_stage;
    logic        sel_rf_w_en, sel_rf_w_data, sel_data_ram_wd, mem_we;
    logic [4:0]  waddr;

    assign store_data      = id_to_exe_q[147:116];
    assign exe_op          = id_to_exe_q[115:112];
    assign sel_stage       = id_to_exe_q[111:109];
    assign sel_rf_w_en     = id_to_exe_q[108];
    assign sel_rf_w_data   = id_to_exe_q[107];
    assign sel_data_ram_wd = id_to_exe_q[106];
    assign mem_we          = id_to_exe_q[105];
    assign b_en            = id_to_exe_q[104:101];
    assign waddr           = id_to_exe_q[100:96];
    assign src2            = id_to_exe_q[95:64];
    assign src1            = id_to_exe_q[63:32];
    assign inst_pc         = id_to_exe_q[31:0];

    logic is_div, is_signed_div;
    assign is_div        = (exe_op >= 4'd11) && (exe_op <= 4'd14);
    assign is_signed_div = (exe_op == 4'd11) || (exe_op == 4'd13);

    // ---------------- handshake / pipeline register ----------------
    assign EXE_allow_in     = ~exe_valid_q | (exe_ready_go & MEM_allow_in);
    assign EXE_to_MEM_valid = exe_valid_q & exe_ready_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exe_valid_q <= 1'b0;
            id_to_exe_q <= '0;
        end else begin
            if (EXE_allow_in) begin
                exe_valid_q <= ID_to_EXE_valid;
            end
            if (ID_to_EXE_valid && EXE_allow_in) begin
                id_to_exe_q <= ID_to_EXE_bus;
            end
        end
    end

    // ---------------- divider FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (exe_valid_q && is_div) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == CW'(DIV_CYCLES - 1)) state_d = S_DONE;
            S_DONE:  if (MEM_allow_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        exe_ready_go = ~is_div | (state_q == S_DONE);
    end

    // ---------------- divider datapath ----------------
    logic [31:0] mag1, mag2;
    logic [32:0] shifted, diff;

    assign mag1 = (is_signed_div && src1[31]) ? -src1 : src1;
    assign mag2 = (is_signed_div && src2[31]) ? -src2 : src2;

    // quo_q starts as the dividend and shifts left; quotient bits fill in
    // from the bottom as dividend bits move into the partial remainder.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        if (state_q == S_IDLE) begin
            if (exe_valid_q && is_div) begin
                cnt_d   = '0;
                quo_d   = mag1;
                rem_d   = '0;
                dvs_d   = mag2;
                q_neg_d = is_signed_div & (src1[31] ^ src2[31]);
                r_neg_d = is_signed_div & src1[31];
                dz_d    = (src2 == 32'd0);
            end
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q + CW'(1);
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    // Divide by zero forces all-ones regardless of the sign fix-up; the
    // remainder already equals |src1| so its sign fix-up restores src1.
    logic [31:0] quo_res, rem_res;
    assign quo_res = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo_q : quo_q);
    assign rem_res = r_neg_q ? -rem_q : rem_q;

    // ---------------- ALU / result select ----------------
    logic [31:0] exe_result;

    always_comb begin
        exe_result = 32'd0;
        case (exe_op)
            4'd0:  exe_result = src1 + src2;
            4'd1:  exe_result = src1 - src2;
            4'd2:  exe_result = src1 & src2;
            4'd3:  exe_result = src1 | src2;
            4'd4:  exe_result = src1 ^ src2;
            4'd5:  exe_result = {31'd0, $signed(src1) < $signed(src2)};
            4'd6:  exe_result = {31'd0, src1 < src2};
            4'd7:  exe_result = src1 << src2[4:0];
            4'd8:  exe_result = src1 >> src2[4:0];
            4'd9:  exe_result = $signed(src1) >>> src2[4:0];
            4'd10: exe_result = src1 * src2;
            4'd11, 4'd12: exe_result = quo_res;
            4'd13, 4'd14: exe_result = rem_res;
            4'd15: exe_result = src2;
            default: exe_result = 32'd0;
        endcase
    end

    // ---------------- memory request ----------------
    assign data_ram_addr   = src1 + src2;
    assign data_ram_en     = exe_valid_q & exe_ready_go & MEM_allow_in & (b_en != 4'd0);
    assign data_ram_we     = (data_ram_en & mem_we) ? b_en : 4'd0;
    assign data_ram_w_data = store_data << {data_ram_addr[1:0], 3'b000};

    // ---------------- output buses ----------------
    logic by_data_valid;
    assign by_data_valid = exe_valid_q & exe_ready_go & sel_stage[0];

    assign EXE_to_MEM_bus = {sel_stage, sel_rf_w_en, sel_rf_w_data, sel_data_ram_wd,
                             b_en, waddr, exe_result, inst_pc};
    assign EXE_to_BY_bus  = {waddr, exe_result, by_data_valid, sel_rf_w_en};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
                           OP_SRL = 4'd8, OP_SRA = 4'd9, OP_MUL = 4'd10, OP_DIV = 4'd11,
                           OP_DIVU = 4'd12, OP_MOD = 4'd13, OP_MODU = 4'd14, OP_LUI = 4'd15;

    logic         clk = 1'b0;
    logic         reset;
    logic [147:0] id_bus;
    logic         id_valid;
    logic         mem_allow;
    logic         exe_allow;
    logic         to_mem_valid;
    logic [78:0]  to_mem_bus;
    logic [38:0]  by_bus;
    logic         ram_en;
    logic [3:0]   ram_we;
    logic [31:0]  ram_addr;
    logic [31:0]  ram_wdata;

    int checks   = 0;
    int failures = 0;

    exe_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ID_to_EXE_bus    (id_bus),
        .ID_to_EXE_valid  (id_valid),
        .EXE_allow_in     (exe_allow),
        .MEM_allow_in     (mem_allow),
        .EXE_to_MEM_valid (to_mem_valid),
        .EXE_to_MEM_bus   (to_mem_bus),
        .EXE_to_BY_bus    (by_bus),
        .data_ram_en      (ram_en),
        .data_ram_we      (ram_we),
        .data_ram_addr    (ram_addr),
        .data_ram_w_data  (ram_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [147:0] mk(input logic [3:0] op, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [3:0] ben,
                                        input logic we, input logic [31:0] sd,
                                        input logic [4:0] wa, input logic [31:0] pc);
        return {sd, op, 3'b001, 1'b1, 1'b0, 1'b0, we, ben, wa, s2, s1, pc};
    endfunction

    // ALU stream vectors, one instruction per cycle
    logic [3:0]  v_op  [12] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
                                OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_LUI};
    logic [31:0] v_a   [12] = '{32'd5, 32'd5, 32'hF0F0_00FF, 32'h0000_00F0,
                                32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
                                32'h8000_0000, 32'h8000_0000, 32'h0001_0003, 32'd0};
    logic [31:0] v_b   [12] = '{32'hFFFF_FFFE, 32'd7, 32'h0FF0_0F0F, 32'h0000_000F,
                                32'h0F0F_0F0F, 32'd1, 32'd1, 32'h0000_0024,
                                32'd31, 32'd4, 32'h0002_0005, 32'h1234_5000};
    logic [31:0] v_exp [12] = '{32'd3, 32'hFFFF_FFFE, 32'h00F0_000F, 32'h0000_00FF,
                                32'hF0F0_0F0F, 32'd1, 32'd0, 32'h10,
                                32'd1, 32'hF800_0000, 32'h000B_000F, 32'h1234_5000};

    task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] exp,
                           input int stall, input logic [3:0] ben);
        logic [78:0] exp_bus;
        exp_bus = {3'b001, 1'b1, 1'b0, 1'b0, ben, 5'd7, exp, 32'h0000_0200};
        id_bus    = mk(op, s1, s2, ben, 1'b0, 32'd0, 5'd7, 32'h0000_0200);
        id_valid  = 1'b1;
        mem_allow = 1'b1;
        @(negedge clk);
        id_valid  = 1'b0;
        mem_allow = (stall == 0);
        for (int c = 0; c <= 32; c++) begin
            chk({tag, "_allow_busy"}, 80'(exe_allow), 80'(1'b0));
            chk({tag, "_valid_busy"}, 80'(to_mem_valid), 80'(1'b0));
            @(negedge clk);
        end
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_stall_valid"}, 80'(to_mem_valid), 80'(1'b1));
            chk({tag, "_stall_bus"}, 80'(to_mem_bus), 80'(exp_bus));
            chk({tag, "_stall_ram_en"}, 80'(ram_en), 80'(1'b0));
            chk({tag, "_stall_allow"}, 80'(exe_allow), 80'(1'b0));
            @(negedge clk);
        end
        mem_allow = 1'b1;
        #1;
        chk({tag, "_done_valid"}, 80'(to_mem_valid), 80'(1'b1));
        chk({tag, "_result"}, 80'(to_mem_bus[63:32]), 80'(exp));
        chk({tag, "_done_allow"}, 80'(exe_allow), 80'(1'b1));
        chk({tag, "_done_ram_en"}, 80'(ram_en), 80'(ben != 4'd0));
        @(negedge clk);
        chk({tag, "_left_valid"}, 80'(to_mem_valid), 80'(1'b0));
        chk({tag, "_left_ram_en"}, 80'(ram_en), 80'(1'b0));
    endtask

    initial begin
        reset     = 1'b0;
        id_bus    = '0;
        id_valid  = 1'b0;
        mem_allow = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_allow", 80'(exe_allow), 80'(1'b1));
        chk("rst_valid", 80'(to_mem_valid), 80'(1'b0));
        chk("rst_bus", 80'(to_mem_bus), 80'(0));
        chk("rst_by", 80'(by_bus), 80'(0));
        chk("rst_ram_en", 80'(ram_en), 80'(1'b0));
        chk("rst_ram_we", 80'(ram_we), 80'(0));
        chk("rst_ram_addr", 80'(ram_addr), 80'(0));
        chk("rst_ram_wdata", 80'(ram_wdata), 80'(0));
        reset = 1'b1;
        @(negedge clk);

        // single ADD, then streaming ALU ops back to back
        id_bus   = mk(OP_ADD, 32'd5, 32'hFFFF_FFFE, 4'd0, 1'b0, 32'd0, 5'd3, 32'h0000_0100);
        id_valid = 1'b1;
        @(negedge clk);
        chk("add_valid", 80'(to_mem_valid), 80'(1'b1));
        chk("add_result", 80'(to_mem_bus[63:32]), 80'(32'd3));
        chk("add_pc", 80'(to_mem_bus[31:0]), 80'(32'h0000_0100));
        chk("add_by", 80'(by_bus), 80'({5'd3, 32'd3, 1'b1, 1'b1}));
        for (int i = 0; i < 12; i++) begin
            id_bus = mk(v_op[i], v_a[i], v_b[i], 4'd0, 1'b0, 32'd0, 5'd4, 32'h0000_0104);
            @(negedge clk);
            chk($sformatf("stream%0d_valid", i), 80'(to_mem_valid), 80'(1'b1));
            chk($sformatf("stream%0d_allow", i), 80'(exe_allow), 80'(1'b1));
            chk($sformatf("stream%0d_result", i), 80'(to_mem_bus[63:32]), 80'(v_exp[i]));
        end
        id_valid = 1'b0;
        @(negedge clk);
        chk("stream_drain_valid", 80'(to_mem_valid), 80'(1'b0));

        // store: lane-aligned write on the transfer cycle only
        id_bus   = mk(OP_ADD, 32'h0000_1000, 32'd2, 4'b1100, 1'b1, 32'h0000_ABCD, 5'd0, 32'h0000_0300);
        id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        chk("st_ram_en", 80'(ram_en), 80'(1'b1));
        chk("st_ram_we", 80'(ram_we), 80'(4'b1100));
        chk("st_ram_addr", 80'(ram_addr), 80'(32'h0000_1002));
        chk("st_ram_wdata", 80'(ram_wdata), 80'(32'hABCD_0000));
        @(negedge clk);
        chk("st_ram_en_off", 80'(ram_en), 80'(1'b0));
        chk("st_ram_we_off", 80'(ram_we), 80'(4'd0));

        // divider
        run_div("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 4'd0);
        run_div("mod_neg", OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 4'd0);
        run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 4'd0);
        run_div("mod_ovf", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 4'd0);
        run_div("div_dz", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0, 4'd0);
        run_div("mod_dz", OP_MOD, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 4'd0);
        run_div("div_stall", OP_DIV, 32'd100, 32'd7, 32'd14, 5, 4'b0011);

        // reset in the middle of a divide
        id_bus    = mk(OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd0, 1'b0, 32'd0, 5'd7, 32'h0000_0400);
        id_valid  = 1'b1;
        mem_allow = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mrst_valid", 80'(to_mem_valid), 80'(1'b0));
        chk("mrst_allow", 80'(exe_allow), 80'(1'b1));
        chk("mrst_ram_en", 80'(ram_en), 80'(1'b0));
        chk("mrst_by", 80'(by_bus), 80'(0));
        @(negedge clk);
        reset    = 1'b1;
        id_bus   = mk(OP_ADD, 32'd10, 32'd20, 4'd0, 1'b0, 32'd0, 5'd2, 32'h0000_0500);
        id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        chk("mrst_add_valid", 80'(to_mem_valid), 80'(1'b1));
        chk("mrst_add_result", 80'(to_mem_bus[63:32]), 80'(32'd30));
        @(negedge clk);

        run_div("divu_dz", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, 4'd0);
        run_div("modu_dz", OP_MODU, 32'd9, 32'd0, 32'd9, 0, 4'd0);
        run_div("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 0, 4'd0);
        run_div("modu_big", OP_MODU, 32'hFFFF_FFF9, 32'd2, 32'd1, 0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
